// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: default geometry, pixel type and
// the small arithmetic helpers used by the post-convolution stages.
package cnn_pkg;

  // Default pixel width of the conv output stream.
  localparam int DEF_DATA_W = 16;

  // Default input line length; shared with matrix_3x3 and conv.
  localparam int DEF_IMG_W  = 480;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

  // Position of a beat inside its 2x2 window, encoded as {odd_row, col[0]}.
  typedef enum logic [1:0] {
    PH_EVEN_LATCH = 2'b00,  // even row, even col: latch left pixel
    PH_EVEN_WRITE = 2'b01,  // even row, odd col: store horizontal max
    PH_ODD_READ   = 2'b10,  // odd row, even col: fetch upper max, latch left
    PH_ODD_EMIT   = 2'b11   // odd row, odd col: emit pooled value
  } beat_phase_e;

  // ReLU on a two's complement pixel: negatives clamp to zero.
  function automatic pixel_t relu(input pixel_t x);
    return x[DEF_DATA_W-1] ? '0 : x;
  endfunction

  // Maximum of two non-negative pixels; the sign bit is always 0 after
  // ReLU, so an unsigned compare is sufficient and cheaper.
  function automatic pixel_t umax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage : cnn_pkg

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Holds the even-row horizontal maxima for the 2x2 pooling stage.
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 240,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port: store one horizontal maximum per even-row window.
  // NOTE: the array has no reset on purpose; a reset branch would stop it
  // mapping onto block RAM, and every address is written before it is read.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered output that holds until the next read enable,
  // so idle input cycles between read and use do not disturb the data.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : pool_line_buf

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 / stride-2 max pooling on the conv pixel stream.
// Even rows store per-window horizontal maxima in a half-width line
// buffer; odd rows combine them with their own horizontal maxima and emit
// one pooled value per window.
module relu_maxpool_2x2 #(
  parameter int DATA_W = cnn_pkg::DEF_DATA_W,
  parameter int IMG_W  = cnn_pkg::DEF_IMG_W   // even and >= 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              data_in_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_out_en,
  output logic [DATA_W-1:0] data_out
);

  import cnn_pkg::*;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ADDR_W = COL_W - 1;          // col >> 1 for an even IMG_W
  localparam int DEPTH  = IMG_W / 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  // Position state
  logic [COL_W-1:0]  r_col;
  logic              r_odd_row;
  logic [DATA_W-1:0] r_h_reg;

  // Output register
  logic              r_data_out_en;
  logic [DATA_W-1:0] r_data_out;

  // Effective position of the current beat: frame_start forces (0,0) so a
  // beat arriving together with it is treated as the first pixel.
  logic [COL_W-1:0]  w_col;
  logic              w_odd_row;
  logic [ADDR_W-1:0] w_addr;
  beat_phase_e       w_phase;

  logic [DATA_W-1:0] w_pix;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_rd_data;

  logic              w_latch;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_emit;

  assign w_col     = frame_start ? '0 : r_col;
  assign w_odd_row = frame_start ? 1'b0 : r_odd_row;
  assign w_addr    = w_col[COL_W-1:1];
  assign w_phase   = beat_phase_e'({w_odd_row, w_col[0]});

  assign w_pix  = relu(data_in);
  assign w_hmax = umax(r_h_reg, w_pix);

  // Decode which action the accepted beat performs in its window.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_latch = 1'b0;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    w_emit  = 1'b0;
    if (data_in_en) begin
      case (w_phase)
        PH_EVEN_LATCH: w_latch = 1'b1;
        PH_EVEN_WRITE: w_wr_en = 1'b1;
        PH_ODD_READ: begin
          w_latch = 1'b1;
          w_rd_en = 1'b1;
        end
        PH_ODD_EMIT:   w_emit  = 1'b1;
        default: ;
      endcase
    end
  end

  // Line buffer: writes happen only on even rows and reads only on odd rows,
  // so the two ports never address the same entry in one cycle.
  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_addr),
    .i_wr_data (w_hmax),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_addr),
    .o_rd_data (w_rd_data)
  );

  // Column counter and row parity; wrap at end of line, restart on frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_odd_row <= 1'b0;
    end else if (data_in_en) begin
      if (w_col == COL_LAST) begin
        r_col     <= '0;
        r_odd_row <= ~w_odd_row;
      end else begin
        r_col     <= w_col + 1'b1;
        r_odd_row <= w_odd_row;
      end
    end else if (frame_start) begin
      r_col     <= '0;
      r_odd_row <= 1'b0;
    end
  end

  // Left pixel of the current window, held until its right-hand partner arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_reg <= '0;
    end else if (w_latch) begin
      r_h_reg <= w_pix;
    end else if (frame_start) begin
      r_h_reg <= '0;
    end
  end

  // Pooled output: one-cycle pulse per window, value held between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out_en <= 1'b0;
      r_data_out    <= '0;
    end else begin
      r_data_out_en <= w_emit;
      if (w_emit) begin
        r_data_out <= umax(w_rd_data, w_hmax);
      end
    end
  end

  assign data_out_en = r_data_out_en;
  assign data_out    = r_data_out;

endmodule : relu_maxpool_2x2
